inst_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/inst_fetch_if.sv | 34 +++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/inst_fetch.sv | 76 +++++++
 tb/tb_inst_fetch.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
//
// Purpose : fetch queue entry layout, PC step sizes, reset PC default and
//           the instruction formatting helper used before enqueue.
// Ports   : none (package).
package fetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_1000;
    localparam logic [63:0] INST_STEP_C      = 64'd2;
    localparam logic [63:0] INST_STEP_W      = 64'd4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
    } fetch_entry_t;

    // Compressed instructions only carry 16 meaningful bits; the upper half
    // from instcache belongs to the next instruction and must not leak out.
    function automatic logic [31:0] fmt_inst(input logic [31:0] raw, input logic comp);
        return comp ? {16'h0000, raw[15:0]} : raw;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instcache, redirect and decode-side signals of the fetch stage
//
// Purpose : bundles the fetch stage's bus signals.
// Modports: master - the fetch stage (drives pc and the fq_* head/occupancy)
//           slave  - the environment (instcache, redirect source, decode)
// Signals : pc, inst_valid, inst_comp, inst, redirect_valid, redirect_pc,
//           fq_valid, fq_ready, fq_pc, fq_inst, fq_comp, fq_count.
interface inst_fetch_if #(
    parameter int DEPTH = 4
);
    logic [63:0]            pc;
    logic                   inst_valid;
    logic                   inst_comp;
    logic [31:0]            inst;
    logic                   redirect_valid;
    logic [63:0]            redirect_pc;
    logic                   fq_valid;
    logic                   fq_ready;
    logic [63:0]            fq_pc;
    logic [31:0]            fq_inst;
    logic                   fq_comp;
    logic [$clog2(DEPTH):0] fq_count;

    modport master (
        output pc, fq_valid, fq_pc, fq_inst, fq_comp, fq_count,
        input  inst_valid, inst_comp, inst, redirect_valid, redirect_pc, fq_ready
    );

    modport slave (
        input  pc, fq_valid, fq_pc, fq_inst, fq_comp, fq_count,
        output inst_valid, inst_comp, inst, redirect_valid, redirect_pc, fq_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order FIFO of fetch entries with flush
//
// Purpose : DEPTH-entry synchronous FIFO; head is read straight from storage.
// Ports   : clk, rst_n        clock, async active-low reset
//           push, pop, flush  enqueue / dequeue / discard all entries
//           din, dout         entry in / head entry out
//           valid, full       head valid / no free slot
//           count             occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push & (~full | do_pop);

    assign dout  = mem_q[rd_q];
    assign count = count_q;

    // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (do_push && !flush) begin
                mem_q[wr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC register, push/redirect control, fetch queue
//
// Purpose : owns the fetch PC, enqueues instcache hits for decode and
//           handles redirects (flush + PC reload).
// Ports   : clk    clock
//           rst_n  async active-low reset
//           bus    inst_fetch_if.master (pc to instcache, inst_* from it,
//                  redirect_*, fq_* handshake toward decode)
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    logic [63:0]  pc_q, pc_d;
    logic         pop;
    logic         push;
    logic         full;
    logic         head_valid;
    fetch_entry_t entry;
    fetch_entry_t head;

    assign pop  = head_valid & bus.fq_ready;
    // A redirect cycle's fetch result belongs to the wrong path; never enqueue it.
    assign push = bus.inst_valid & ~bus.redirect_valid & (~full | pop);

    assign entry.pc   = pc_q;
    assign entry.inst = fmt_inst(bus.inst, bus.inst_comp);
    assign entry.comp = bus.inst_comp;

    // PC only moves on push or redirect, so instcache sees a stable address
    // for the whole duration of a refill.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = {bus.redirect_pc[63:1], 1'b0};
        end else if (push) begin
            pc_d = pc_q + (bus.inst_comp ? INST_STEP_C : INST_STEP_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (entry),
        .dout  (head),
        .valid (head_valid),
        .full  (full),
        .count (bus.fq_count)
    );

    assign bus.pc       = pc_q;
    assign bus.fq_valid = head_valid;
    assign bus.fq_pc    = head.pc;
    assign bus.fq_inst  = head.inst;
    assign bus.fq_comp  = head.comp;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    ent_t exp_q [$];
    logic [63:0] m_pc;

    inst_fetch_if #(.DEPTH(DEPTH)) bus ();

    inst_fetch #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Check the model state at this negedge, then drive one cycle of inputs
    // and advance the model by what the spec says that cycle must do.
    task automatic step(input logic iv, input logic cm, input logic [31:0] ins,
                        input logic rv, input logic [63:0] rpc, input logic rdy);
        bit   m_pop;
        bit   m_full;
        ent_t e;
        @(negedge clk);
        chk("pc", bus.pc, m_pc);
        chk("fq_count", 64'(bus.fq_count), 64'(exp_q.size()));
        chk("fq_valid", 64'(bus.fq_valid), 64'(exp_q.size() != 0));
        bus.inst_valid     = iv;
        bus.inst_comp      = cm;
        bus.inst           = ins;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.fq_ready       = rdy;
        if (rv) begin
            exp_q.delete();
            m_pc = rpc & ~64'd1;
        end else begin
            m_pop  = (exp_q.size() > 0) && rdy;
            m_full = (exp_q.size() == DEPTH);
            if (iv && (!m_full || m_pop)) begin
                e.pc   = m_pc;
                e.inst = cm ? (ins & 32'h0000_FFFF) : ins;
                e.comp = cm;
                exp_q.push_back(e);
                m_pc = m_pc + (cm ? 64'd2 : 64'd4);
            end
        end
    endtask

    // Monitor: whenever decode takes the head (outside a redirect cycle),
    // pop the scoreboard and compare.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.fq_valid && bus.fq_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL head_pop: got pc %0h with nothing expected", bus.fq_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("fq_pc", bus.fq_pc, e.pc);
                    chk("fq_inst", 64'(bus.fq_inst), 64'(e.inst));
                    chk("fq_comp", 64'(bus.fq_comp), 64'(e.comp));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_pc     = RPC;
        rst_n    = 1'b0;
        bus.inst_valid     = 1'b0;
        bus.inst_comp      = 1'b0;
        bus.inst           = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.fq_ready       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fq_pc", bus.fq_pc, 64'h0);
        chk("rst_fq_inst", 64'(bus.fq_inst), 64'h0);
        chk("rst_fq_comp", 64'(bus.fq_comp), 64'h0);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        chk("idle_pc", bus.pc, 64'h1000);

        // Word, compressed (upper bits garbage), word.
        step(1'b1, 1'b0, 32'h0000_0013, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b1, 32'hABCD_0001, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0010_0093, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        chk("seq_pc", bus.pc, 64'h100A);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);

        // Backpressure: fill, hold, then push+pop while full.
        step(1'b0, 1'b0, 32'h0, 1'b1, 64'h1000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h1000_0000 + i, 1'b0, 64'h0, 1'b0);
        chk("bp_pc", bus.pc, 64'h1010);
        chk("bp_count", 64'(bus.fq_count), 64'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h2000_0000 + i, 1'b0, 64'h0, 1'b1);
        chk("bp_pp_count", 64'(bus.fq_count), 64'd4);

        // Miss at 0x2000 for 10 cycles, then a hit.
        step(1'b0, 1'b0, 32'h0, 1'b1, 64'h2000, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b1);
        chk("miss_pc", bus.pc, 64'h2000);
        step(1'b1, 1'b0, 32'h0000_0033, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        chk("miss_hit_pc", bus.pc, 64'h2004);

        // Redirect with 3 queued entries and a simultaneous pop/hit.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h3000_0000 + i, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 32'h3333_3333, 1'b1, 64'h8001, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        chk("redir_pc", bus.pc, 64'h8000);
        chk("redir_valid", 64'(bus.fq_valid), 64'd0);
        chk("redir_count", 64'(bus.fq_count), 64'd0);

        // 64-bit PC wrap.
        step(1'b0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(1'b1, 1'b0, 32'h0000_0013, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        chk("wrap_pc", bus.pc, 64'h2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), $urandom,
                 ($urandom_range(0, 19) == 0), {$urandom, $urandom},
                 ($urandom_range(0, 9) < 6));
        end

        // Async reset between edges with a full queue.
        step(1'b0, 1'b0, 32'h0, 1'b1, 64'h4000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h5000_0000 + i, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", 64'(bus.fq_count), 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 64'h1000);
        chk("arst_valid", 64'(bus.fq_valid), 64'd0);
        chk("arst_count", 64'(bus.fq_count), 64'd0);
        exp_q.delete();
        m_pc = RPC;
        bus.inst_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0000_0013, 1'b0, 64'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
